// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device byte transmitter (open-drain line control)
//               Inhibits the bus by holding clock low, issues the start bit,
//               shifts 8 data bits LSB first plus odd parity on device falling
//               edges, releases the stop bit and samples the device ACK.
// Ports       : CLOCK_50   - system clock, rising edge
//               resetn     - asynchronous active-low reset
//               send_req   - one-cycle request, accepted only while idle
//               send_data  - byte captured with an accepted request
//               PS2_CLK    - PS/2 clock line as seen on the pin
//               PS2_DAT    - PS/2 data line as seen on the pin
//               ps2_clk_oe - 1 pulls the clock line low
//               ps2_dat_oe - 1 pulls the data line low
//               busy       - transfer in progress
//               done       - one-cycle pulse: byte sent and ACK received
//               error      - one-cycle pulse: no ACK (or watchdog expiry)
// Options     : define PS2_TX_TIMEOUT_EN to enable the transfer watchdog
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       send_req,
    input  logic [7:0] send_data,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
`else
    localparam int CNT_MAX = INHIBIT_CYCLES;
`endif
    localparam int             CNT_W        = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    // Both cycle counts must be at least one for the counter compares to work.
    if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    logic [2:0]       state_q, state_d;
    logic             clk_s1_q, clk_s2_q, clk_s3_q;
    logic             dat_s1_q, dat_s2_q;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dat_oe_q, dat_oe_d;
    logic             ack_ok_q, ack_ok_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             fall;

    // Falling edge of the synchronized device clock.
    assign fall = clk_s3_q & ~clk_s2_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_s3_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            data_q     <= 8'h00;
            parity_q   <= 1'b0;
            edge_cnt_q <= 4'd0;
            cnt_q      <= '0;
            dat_oe_q   <= 1'b0;
            ack_ok_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_s3_q   <= clk_s2_q;
            dat_s1_q   <= PS2_DAT;
            dat_s2_q   <= dat_s1_q;
            data_q     <= data_d;
            parity_q   <= parity_d;
            edge_cnt_q <= edge_cnt_d;
            cnt_q      <= cnt_d;
            dat_oe_q   <= dat_oe_d;
            ack_ok_q   <= ack_ok_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        parity_d   = parity_q;
        edge_cnt_d = edge_cnt_q;
        cnt_d      = cnt_q;
        dat_oe_d   = dat_oe_q;
        ack_ok_d   = ack_ok_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                dat_oe_d = 1'b0;
                if (send_req) begin
                    data_d     = send_data;
                    parity_d   = ~^send_data;
                    edge_cnt_d = 4'd0;
                    cnt_d      = '0;
                    state_d    = S_INHIBIT;
                end
            end
            // Line activity is deliberately not looked at while inhibiting.
            S_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    dat_oe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Old edge count 0..7 selects data bit, 8 the parity, 9 the stop.
            S_START, S_SHIFT: begin
                if (fall) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    state_d    = S_SHIFT;
                    if (edge_cnt_q < 4'd8) begin
                        dat_oe_d = ~data_q[edge_cnt_q[2:0]];
                    end else if (edge_cnt_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    ack_ok_d   = ~dat_s2_q;
                    state_d    = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (clk_s2_q && dat_s2_q) begin
                    done_d  = ack_ok_q;
                    error_d = ~ack_ok_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog spans START through RELEASE; it overrides any completion.
        if (state_q == S_START || state_q == S_SHIFT ||
            state_q == S_ACK   || state_q == S_RELEASE) begin
            if (cnt_q == TIMEOUT_LAST) begin
                dat_oe_d = 1'b0;
                done_d   = 1'b0;
                error_d  = 1'b1;
                state_d  = S_IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from the reset-cleared state so reset releases lines
    // without waiting for a clock)
    // ------------------------------------------------------------------
    always_comb begin
        ps2_clk_oe = (state_q == S_INHIBIT);
        ps2_dat_oe = dat_oe_q;
        busy       = (state_q != S_IDLE);
        done       = done_q;
        error      = error_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Scoreboard bench for ps2_host_tx with a PS/2 device model.
//               Stimulus pushes expected outcomes; a monitor pops and checks
//               them on every done/error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INHIBIT = 5000;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       send_req = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       PS2_CLK, PS2_DAT;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;

    // Open-drain wired-AND of host and device.
    assign PS2_CLK = dev_clk & ~ps2_clk_oe;
    assign PS2_DAT = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .send_req   (send_req),
        .send_data  (send_data),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string     name;
        bit        exp_done;
        bit        chk_bits;
        bit [7:0]  bits;
        bit        par;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    bit [7:0] obs_bits;
    bit       obs_par;
    bit       obs_stop;
    int       inh_run  = 0;
    int       last_inh = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        send_data = d;
        send_req  = 1'b1;
        cyc(1);
        send_req  = 1'b0;
    endtask

    // Device side of one host-to-device frame. abort_edge>0 pulls resetn low
    // shortly after that falling edge and checks the asynchronous release.
    task automatic device_xfer(input bit ack, input int abort_edge);
        int t;
        t = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && t < 20000) begin
            cyc(1);
            t++;
        end
        if (t >= 20000) begin
            chk("rts_wait_timeout", 32'(t), 32'd0);
            return;
        end
        cyc(HALF);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && ack) dev_dat = 1'b0;
            dev_clk = 1'b0;
            if (e == abort_edge) begin
                cyc(4);
                resetn = 1'b0;
                #1;
                chk("async_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
                chk("async_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
                chk("async_rst_busy",   32'(busy),       32'd0);
                dev_clk = 1'b1;
                dev_dat = 1'b1;
                cyc(5);
                resetn = 1'b1;
                return;
            end
            cyc(HALF);
            if (e <= 8)       obs_bits[e-1] = PS2_DAT;
            else if (e == 9)  obs_par       = PS2_DAT;
            else if (e == 10) obs_stop      = PS2_DAT;
            dev_clk = 1'b1;
            cyc(HALF);
        end
        dev_dat = 1'b1;
    endtask

    task automatic txn(input string name, input logic [7:0] d, input bit ack,
                       input logic [7:0] exp_bits, input bit exp_par);
        exp_t e;
        e.name     = name;
        e.exp_done = ack;
        e.chk_bits = 1'b1;
        e.bits     = exp_bits;
        e.par      = exp_par;
        exp_q.push_back(e);
        obs_bits = 8'h00;
        obs_par  = 1'b0;
        obs_stop = 1'b0;
        send(d);
        device_xfer(ack, 0);
        cyc(20);
    endtask

    // Length of the most recent clock-inhibit interval.
    always @(negedge clk) begin
        if (ps2_clk_oe) begin
            inh_run <= inh_run + 1;
        end else if (inh_run != 0) begin
            last_inh <= inh_run;
            inh_run  <= 0;
        end
    end

    // Scoreboard monitor.
    exp_t m_e;
    always @(negedge clk) begin
        if (done || error) begin
            chk("done_and_error_exclusive", 32'(done & error), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse_done", 32'(done), 32'd0);
                chk("unexpected_pulse_error", 32'(error), 32'd0);
            end else begin
                m_e = exp_q.pop_front();
                chk({m_e.name, "_done"},  32'(done),  32'(m_e.exp_done));
                chk({m_e.name, "_error"}, 32'(error), 32'(!m_e.exp_done));
                if (m_e.chk_bits) begin
                    chk({m_e.name, "_bits"},    32'(obs_bits), 32'(m_e.bits));
                    chk({m_e.name, "_parity"},  32'(obs_par),  32'(m_e.par));
                    chk({m_e.name, "_stop"},    32'(obs_stop), 32'd1);
                    chk({m_e.name, "_inhibit"}, 32'(last_inh), 32'(INHIBIT));
                end
            end
            @(negedge clk);
            chk("busy_after_pulse", 32'(busy), 32'd0);
        end
    end

    initial begin
        int t;
        cyc(3);
        chk("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("reset_busy",   32'(busy),       32'd0);
        chk("reset_done",   32'(done),       32'd0);
        chk("reset_error",  32'(error),      32'd0);
        resetn = 1'b1;
        cyc(5);

        // 0xED: bits LSB first 1,0,1,1,0,1,1,1 ; six ones -> parity 1
        txn("ed", 8'hED, 1'b1, 8'b1110_1101, 1'b1);
        // 0xF4: bits 0,0,1,0,1,1,1,1 ; five ones -> parity 0
        txn("f4", 8'hF4, 1'b1, 8'b1111_0100, 1'b0);
        // 0xFF without ACK: parity 1, error pulse expected
        txn("ff_noack", 8'hFF, 1'b0, 8'b1111_1111, 1'b1);

        // Second request while busy is ignored; reset at edge 5 aborts
        // silently (no scoreboard entry, so any pulse is flagged).
        send(8'h3C);
        cyc(100);
        send(8'h55);
        cyc(2);
        chk("busy_during_inhibit", 32'(busy), 32'd1);
        device_xfer(1'b1, 5);
        cyc(50);
        chk("idle_after_abort", 32'(busy), 32'd0);

        // 0x00: all zeros, parity 1
        txn("zero", 8'h00, 1'b1, 8'b0000_0000, 1'b1);

`ifdef PS2_TX_TIMEOUT_EN
        begin
            exp_t e;
            int   k;
            e.name = "timeout"; e.exp_done = 1'b0; e.chk_bits = 1'b0;
            e.bits = 8'h00;     e.par = 1'b0;
            exp_q.push_back(e);
            send(8'h12);
            t = 0;
            while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
            while (ps2_clk_oe && t < 20000) begin @(negedge clk); t++; end
            k = 0;
            while (!error && k < TIMEOUT + 500) begin @(negedge clk); k++; end
            chk("timeout_latency", 32'(k), 32'(TIMEOUT));
            chk("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
            chk("timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
            cyc(20);
        end
`endif

        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin cyc(1); t++; end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        cyc(10);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clock-low inhibit time in CLOCK_50 cycles (100 us).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, transfer watchdog in CLOCK_50 cycles (15 ms).
REQ-003 CLOCK_50  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 send_req  input  1  single-cycle request; accepted only while busy=0.
REQ-006 send_data  input  8  command byte, captured in the cycle send_req is accepted.
REQ-007 PS2_CLK  input  1  sampled PS/2 clock line.
REQ-008 PS2_DAT  input  1  sampled PS/2 data line.
REQ-009 ps2_clk_oe  output  1  1 = drive PS2 clock low; 0 = release (open-drain).
REQ-010 ps2_dat_oe  output  1  1 = drive PS2 data low; 0 = release.
REQ-011 busy  output  1  high from the cycle after acceptance until done/error pulses.
REQ-012 done  output  1  one-cycle pulse: byte sent and device ACK received.
REQ-013 error  output  1  one-cycle pulse: missing ACK or timeout.

Function
REQ-014 PS2_CLK and PS2_DAT SHALL each pass through a 2-flop synchronizer; a device falling edge is detected as synchronized 1->0.
REQ-015 States: IDLE, INHIBIT, START, SHIFT, ACK, RELEASE; IDLE holds both oe low.
REQ-016 IDLE + send_req: latch send_data; compute odd parity (parity bit = ~^data); enter INHIBIT with ps2_clk_oe=1.
REQ-017 INHIBIT: hold ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then assert ps2_dat_oe=1 (start bit) and enter START.
REQ-018 START: release ps2_clk_oe in the cycle after entry, keep ps2_dat_oe=1, wait for first falling edge.
REQ-019 SHIFT: on falling edges 1..8, set ps2_dat_oe = ~data[n], LSB first; edge 9: ps2_dat_oe = ~parity; edge 10: ps2_dat_oe=0 (stop); then enter ACK.
REQ-020 ACK: on falling edge 11, synchronized PS2_DAT=0 -> RELEASE with ack_ok=1; PS2_DAT=1 -> RELEASE with ack_ok=0.
REQ-021 RELEASE: wait until synchronized PS2_CLK and PS2_DAT both 1, then pulse done (ack_ok=1) or error (ack_ok=0) and return to IDLE.
REQ-022 A 4-bit edge counter SHALL count falling edges 0..11, cleared on entry to INHIBIT.
REQ-023 send_req while busy=1 SHALL be ignored; no queueing.
REQ-024 done and error SHALL never be asserted in the same cycle.
REQ-025 Line changes during INHIBIT (device activity) SHALL be ignored.

Reset
REQ-026 resetn=0 SHALL immediately force IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0, edge counter=0, synchronizers=1.
REQ-027 Reset mid-transfer SHALL release both lines within the same asynchronous assertion; no done/error pulse.

Configuration
REQ-028 Macro PS2_TX_TIMEOUT_EN defined: a counter runs from START to RELEASE exit; reaching TIMEOUT_CYCLES SHALL release both lines, pulse error, return to IDLE.
REQ-029 PS2_TX_TIMEOUT_EN undefined: no watchdog logic; the FSM waits indefinitely for device edges.

Verification
REQ-030 send 0xED, device model ACKs -> clk held low 5000 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, done pulse, busy falls.
REQ-031 send 0xF4, device ACKs -> bits 0,0,1,0,1,1,1,1, parity 0, done=1, error=0.
REQ-032 send 0xFF, device leaves data high at edge 11 -> parity 1, error pulse, no done.
REQ-033 With PS2_TX_TIMEOUT_EN, device never clocks -> error pulse exactly TIMEOUT_CYCLES after START entry; both oe=0.
REQ-034 send_req repeated during busy, then resetn=0 at edge 5 -> second request ignored; oe outputs 0 and busy 0 asynchronously; next send of 0x00 completes with parity 1.
